// File: rtl/avalon_sram_master.sv
// Avalon-MM master that programs the SRAM-test register slave, kicks it, polls for
// completion and reads back the result. Optional poll timeout: SRAM_MASTER_TIMEOUT_EN.
module avalon_sram_master #(
    parameter int DONE_BIT = 0,
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cfg_sta_addr,
    input  logic [31:0] cfg_area,
    input  logic [31:0] cfg_op,
    input  logic [31:0] cfg_enable,
    output logic        m_chipselect,
    output logic [2:0]  m_address,
    output logic        m_write,
    output logic        m_read,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] res_addr,
    output logic [31:0] res_data,
    output logic [31:0] res_status
);

    // state   | meaning
    // IDLE    | waiting for start
    // WR_STA  | write reg 0 (start address)
    // WR_AREA | write reg 1 (area)
    // WR_OP   | write reg 2 (operation)
    // WR_EN   | write reg 4 (enable)
    // WR_SEND | write reg 3 = 1
    // WR_CLR  | write reg 3 = 0
    // POLL    | read status reg 7
    // GAP     | idle bus between polls
    // RD_ADDR | read result address reg 5
    // RD_DATA | read result data reg 6
    // FIN     | done pulse, back to IDLE
    typedef enum logic [3:0] {
        IDLE,
        WR_STA,
        WR_AREA,
        WR_OP,
        WR_EN,
        WR_SEND,
        WR_CLR,
        POLL,
        GAP,
        RD_ADDR,
        RD_DATA,
        FIN
    } state_t;

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t state;
    state_t state_nx;

    logic [31:0]      cfg_sta_addr_q;
    logic [31:0]      cfg_area_q;
    logic [31:0]      cfg_op_q;
    logic [31:0]      cfg_enable_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             xfer_ok;
    logic             status_done;
    logic             poll_limit;
    logic             start_ok;

    assign xfer_ok     = m_chipselect & (m_read | m_write) & ~m_waitrequest;
    assign status_done = m_readdata[DONE_BIT];
    assign start_ok    = (state == IDLE) & start;

`ifdef SRAM_MASTER_TIMEOUT_EN
    localparam int PC_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(POLL_MAX - 1);

    logic [PC_W-1:0] poll_cnt;
    logic            timed_out_q;

    // Down-counter reaches zero on the POLL_MAX-th poll.
    assign poll_limit = (poll_cnt == '0);
    assign timeout    = (state == FIN) & timed_out_q;
`else
    logic unused_poll_max;

    assign unused_poll_max = (POLL_MAX != 0);
    assign poll_limit      = 1'b0;
    assign timeout         = 1'b0;
`endif

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        m_chipselect = 1'b0;
        m_address    = 3'd0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        m_writedata  = 32'd0;
        case (state)
            IDLE: begin
                if (start) state_nx = WR_STA;
            end
            WR_STA: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd0;
                m_writedata  = cfg_sta_addr_q;
                if (xfer_ok) state_nx = WR_AREA;
            end
            WR_AREA: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd1;
                m_writedata  = cfg_area_q;
                if (xfer_ok) state_nx = WR_OP;
            end
            WR_OP: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd2;
                m_writedata  = cfg_op_q;
                if (xfer_ok) state_nx = WR_EN;
            end
            WR_EN: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd4;
                m_writedata  = cfg_enable_q;
                if (xfer_ok) state_nx = WR_SEND;
            end
            WR_SEND: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd3;
                m_writedata  = 32'd1;
                if (xfer_ok) state_nx = WR_CLR;
            end
            WR_CLR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd3;
                m_writedata  = 32'd0;
                if (xfer_ok) state_nx = POLL;
            end
            POLL: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd7;
                if (xfer_ok) begin
                    if (status_done)     state_nx = RD_ADDR;
                    else if (poll_limit) state_nx = FIN;
                    else if (POLL_GAP == 0) state_nx = POLL;
                    else                 state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nx = POLL;
            end
            RD_ADDR: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd5;
                if (xfer_ok) state_nx = RD_DATA;
            end
            RD_DATA: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd6;
                if (xfer_ok) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_sta_addr_q <= 32'd0;
            cfg_area_q     <= 32'd0;
            cfg_op_q       <= 32'd0;
            cfg_enable_q   <= 32'd0;
            gap_cnt        <= '0;
            res_addr       <= 32'd0;
            res_data       <= 32'd0;
            res_status     <= 32'd0;
        end else begin
            if (start_ok) begin
                cfg_sta_addr_q <= cfg_sta_addr;
                cfg_area_q     <= cfg_area;
                cfg_op_q       <= cfg_op;
                cfg_enable_q   <= cfg_enable;
            end
            if ((state == POLL) && xfer_ok) begin
                res_status <= m_readdata;
                if (!status_done) gap_cnt <= GAP_LOAD;
            end
            if ((state == GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - 1'b1;
            if ((state == RD_ADDR) && xfer_ok) res_addr <= m_readdata;
            if ((state == RD_DATA) && xfer_ok) res_data <= m_readdata;
        end
    end

`ifdef SRAM_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (start_ok) begin
                poll_cnt    <= PC_LOAD;
                timed_out_q <= 1'b0;
            end
            if ((state == POLL) && xfer_ok && !status_done) begin
                if (poll_limit) timed_out_q <= 1'b1;
                else            poll_cnt    <= poll_cnt - 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avalon_sram_master.sv
// Directed bench for avalon_sram_master with a zero-latency register slave model.
// Timeout scenario is exercised when SRAM_MASTER_TIMEOUT_EN is defined.
module tb_avalon_sram_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] cfg_sta_addr;
    logic [31:0] cfg_area;
    logic [31:0] cfg_op;
    logic [31:0] cfg_enable;
    logic        m_chipselect;
    logic [2:0]  m_address;
    logic        m_write;
    logic        m_read;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] res_addr;
    logic [31:0] res_data;
    logic [31:0] res_status;

    int vectors = 0;
    int miscompares = 0;

    avalon_sram_master #(
        .DONE_BIT (0),
        .POLL_GAP (4),
        .POLL_MAX (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_sta_addr  (cfg_sta_addr),
        .cfg_area      (cfg_area),
        .cfg_op        (cfg_op),
        .cfg_enable    (cfg_enable),
        .m_chipselect  (m_chipselect),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .res_addr      (res_addr),
        .res_data      (res_data),
        .res_status    (res_status)
    );

    always #5 clk = ~clk;

    // Slave model: status = 0xABC0 | poll_index<<4, bit0 set from poll number done_poll on
    int          done_poll;
    int          poll_seen;
    logic        poll_clr;
    logic [31:0] reg5;
    logic [31:0] reg6;

    always @(posedge clk) begin
        if (poll_clr) poll_seen <= 0;
        else if (m_chipselect && m_read && !m_waitrequest && m_address == 3'd7)
            poll_seen <= poll_seen + 1;
    end

    always_comb begin
        m_readdata = 32'hDEAD_0000;
        case (m_address)
            3'd7: m_readdata = 32'hABC0 | (32'(poll_seen) << 4) |
                               (((done_poll != 0) && (poll_seen + 1 >= done_poll)) ? 32'd1 : 32'd0);
            3'd5: m_readdata = reg5;
            3'd6: m_readdata = reg6;
            default: m_readdata = 32'hDEAD_0000;
        endcase
    end

    // Transaction log filled by run_seq
    logic        log_wr   [64];
    logic [2:0]  log_addr [64];
    logic [31:0] log_data [64];
    int          log_n    [64];
    int          log_cnt;
    int          done_n;
    int          done_cnt;
    int          tmo_n;
    int          tmo_cnt;
    int          idle_busy;
    int          stall_op_left;
    int          stall_rd_left;

    task automatic set_cfg(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        cfg_sta_addr = a;
        cfg_area     = b;
        cfg_op       = c;
        cfg_enable   = d;
    endtask

    // Launch a sequence and observe `window` cycles; n=1 is the cycle after the accepting edge.
    task automatic run_seq(input int window, input int extra_start_n);
        logic        prev_wait;
        logic [38:0] prev_bus;
        log_cnt   = 0;
        done_n    = -1;
        done_cnt  = 0;
        tmo_n     = -1;
        tmo_cnt   = 0;
        idle_busy = 0;
        prev_wait = 1'b0;
        prev_bus  = '0;
        poll_clr  = 1'b1;
        @(negedge clk);
        poll_clr  = 1'b0;
        start     = 1'b1;
        for (int n = 1; n <= window; n++) begin
            @(negedge clk);
            start = (n == extra_start_n);
            if (prev_wait) begin
                vectors++;
                if ({m_chipselect, m_write, m_read, m_address, m_writedata} !== prev_bus) begin
                    miscompares++;
                    $display("FAIL stall_stable n=%0d: got %0h required %0h", n,
                             {m_chipselect, m_write, m_read, m_address, m_writedata}, prev_bus);
                end
            end
            vectors++;
            if ((m_read && m_write) || (m_chipselect && !(m_read || m_write))) begin
                miscompares++;
                $display("FAIL strobe_rules n=%0d: got cs=%0b rd=%0b wr=%0b required legal combo",
                         n, m_chipselect, m_read, m_write);
            end
            m_waitrequest = 1'b0;
            if (m_chipselect && m_write && m_address == 3'd2 && stall_op_left > 0) begin
                m_waitrequest = 1'b1;
                stall_op_left--;
            end
            if (m_chipselect && m_read && m_address == 3'd6 && stall_rd_left > 0) begin
                m_waitrequest = 1'b1;
                stall_rd_left--;
            end
            prev_wait = m_waitrequest;
            prev_bus  = {m_chipselect, m_write, m_read, m_address, m_writedata};
            if (m_chipselect && (m_read || m_write) && !m_waitrequest && log_cnt < 64) begin
                log_wr[log_cnt]   = m_write;
                log_addr[log_cnt] = m_address;
                log_data[log_cnt] = m_write ? m_writedata : m_readdata;
                log_n[log_cnt]    = n;
                log_cnt++;
            end
            if (busy && !m_chipselect) idle_busy++;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (timeout) begin
                tmo_cnt++;
                if (tmo_n < 0) tmo_n = n;
            end
        end
        start         = 1'b0;
        m_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy, done, timeout, m_chipselect, m_read, m_write, m_address, m_writedata} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %0h required 0",
                     {busy, done, timeout, m_chipselect, m_read, m_write, m_address, m_writedata});
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_res: got %0h required 0", {res_addr, res_data, res_status});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [35:0] exp_ops [9];
        exp_ops[0] = {1'b1, 3'd0, 32'h10};
        exp_ops[1] = {1'b1, 3'd1, 32'h20};
        exp_ops[2] = {1'b1, 3'd2, 32'h3};
        exp_ops[3] = {1'b1, 3'd4, 32'h1};
        exp_ops[4] = {1'b1, 3'd3, 32'h1};
        exp_ops[5] = {1'b1, 3'd3, 32'h0};
        exp_ops[6] = {1'b0, 3'd7, 32'hABC1};
        exp_ops[7] = {1'b0, 3'd5, 32'h3FF};
        exp_ops[8] = {1'b0, 3'd6, 32'hA5};
        set_cfg(32'h10, 32'h20, 32'h3, 32'h1);
        done_poll = 1;
        reg5 = 32'h3FF;
        reg6 = 32'hA5;
        run_seq(14, 0);
        vectors++;
        if (log_cnt !== 9) begin
            miscompares++;
            $display("FAIL basic_opcount: got %0d required 9", log_cnt);
        end
        for (int i = 0; i < 9 && i < log_cnt; i++) begin
            vectors++;
            if ({log_wr[i], log_addr[i], log_data[i]} !== exp_ops[i] || log_n[i] !== i + 1) begin
                miscompares++;
                $display("FAIL basic_op%0d: got %0h@%0d required %0h@%0d", i,
                         {log_wr[i], log_addr[i], log_data[i]}, log_n[i], exp_ops[i], i + 1);
            end
        end
        vectors++;
        if (done_n !== 10 || done_cnt !== 1 || tmo_cnt !== 0) begin
            miscompares++;
            $display("FAIL basic_done: got n=%0d cnt=%0d tmo=%0d required n=10 cnt=1 tmo=0",
                     done_n, done_cnt, tmo_cnt);
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== {32'h3FF, 32'hA5, 32'hABC1}) begin
            miscompares++;
            $display("FAIL basic_res: got %0h %0h %0h required 3ff a5 abc1", res_addr, res_data, res_status);
        end
        vectors++;
        if (idle_busy !== 0) begin
            miscompares++;
            $display("FAIL basic_idle: got %0d required 0", idle_busy);
        end
    endtask

    task automatic test_polling();
        int polls;
        int poll_at [3];
        set_cfg(32'h100, 32'h200, 32'h7, 32'h1);
        done_poll = 3;
        reg5 = 32'h123;
        reg6 = 32'h456;
        run_seq(24, 0);
        polls = 0;
        for (int i = 0; i < log_cnt; i++) begin
            if (!log_wr[i] && log_addr[i] == 3'd7) begin
                if (polls < 3) poll_at[polls] = log_n[i];
                polls++;
            end
        end
        vectors++;
        if (polls !== 3) begin
            miscompares++;
            $display("FAIL poll_count: got %0d required 3", polls);
        end else begin
            vectors++;
            if (poll_at[0] !== 7 || poll_at[1] !== 12 || poll_at[2] !== 17) begin
                miscompares++;
                $display("FAIL poll_cycles: got %0d,%0d,%0d required 7,12,17",
                         poll_at[0], poll_at[1], poll_at[2]);
            end
        end
        vectors++;
        if (idle_busy !== 8) begin
            miscompares++;
            $display("FAIL poll_gap_idle: got %0d required 8", idle_busy);
        end
        vectors++;
        if (done_n !== 20 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL poll_done: got n=%0d cnt=%0d required n=20 cnt=1", done_n, done_cnt);
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== {32'h123, 32'h456, 32'hABE1}) begin
            miscompares++;
            $display("FAIL poll_res: got %0h %0h %0h required 123 456 abe1", res_addr, res_data, res_status);
        end
        vectors++;
        if (log_cnt !== 11 || log_data[2] !== 32'h7 || log_addr[9] !== 3'd5 || log_addr[10] !== 3'd6) begin
            miscompares++;
            $display("FAIL poll_ops: got cnt=%0d op=%0h a9=%0d a10=%0d required 11 7 5 6",
                     log_cnt, log_data[2], log_addr[9], log_addr[10]);
        end
    endtask

    task automatic test_waitrequest();
        logic [2:0] exp_addr [9];
        int         exp_n    [9];
        exp_addr = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd7, 3'd5, 3'd6};
        exp_n    = '{1, 2, 6, 7, 8, 9, 10, 11, 14};
        set_cfg(32'h10, 32'h20, 32'h3, 32'h1);
        done_poll     = 1;
        reg5          = 32'h55;
        reg6          = 32'h66;
        stall_op_left = 3;
        stall_rd_left = 2;
        run_seq(20, 0);
        vectors++;
        if (log_cnt !== 9) begin
            miscompares++;
            $display("FAIL wait_opcount: got %0d required 9", log_cnt);
        end
        for (int i = 0; i < 9 && i < log_cnt; i++) begin
            vectors++;
            if (log_addr[i] !== exp_addr[i] || log_n[i] !== exp_n[i]) begin
                miscompares++;
                $display("FAIL wait_op%0d: got a%0d@%0d required a%0d@%0d", i,
                         log_addr[i], log_n[i], exp_addr[i], exp_n[i]);
            end
        end
        vectors++;
        if (done_n !== 15 || stall_op_left !== 0 || stall_rd_left !== 0) begin
            miscompares++;
            $display("FAIL wait_done: got n=%0d stalls=%0d/%0d required n=15 0/0",
                     done_n, stall_op_left, stall_rd_left);
        end
        vectors++;
        if ({res_addr, res_data} !== {32'h55, 32'h66}) begin
            miscompares++;
            $display("FAIL wait_res: got %0h %0h required 55 66", res_addr, res_data);
        end
        stall_op_left = 0;
        stall_rd_left = 0;
    endtask

    task automatic test_busy_start();
        set_cfg(32'h1, 32'h2, 32'h3, 32'h4);
        done_poll = 1;
        reg5 = 32'h77;
        reg6 = 32'h88;
        run_seq(22, 4);
        vectors++;
        if (done_cnt !== 1 || done_n !== 10 || log_cnt !== 9) begin
            miscompares++;
            $display("FAIL busy_start: got done=%0d n=%0d ops=%0d required 1 10 9",
                     done_cnt, done_n, log_cnt);
        end
        vectors++;
        if (res_data !== 32'h88) begin
            miscompares++;
            $display("FAIL busy_start_res: got %0h required 88", res_data);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_cfg(32'h9, 32'h9, 32'h9, 32'h9);
        done_poll = 0;
        poll_clr  = 1'b1;
        @(negedge clk);
        poll_clr = 1'b0;
        start    = 1'b1;
        seen     = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_read && m_address == 3'd7) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_mid_reach_poll: got no poll required poll within 20 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, timeout, m_chipselect, m_read, m_write, m_address, m_writedata,
             res_addr, res_data, res_status} !== 136'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got busy=%0b cs=%0b ra=%0h rd=%0h rs=%0h required all 0",
                     busy, m_chipselect, res_addr, res_data, res_status);
        end
        reset = 1'b0;
        set_cfg(32'h10, 32'h20, 32'h3, 32'h1);
        done_poll = 1;
        reg5 = 32'h31;
        reg6 = 32'h32;
        run_seq(14, 0);
        vectors++;
        if (done_n !== 10 || log_cnt !== 9 || log_data[0] !== 32'h10 || log_data[3] !== 32'h1) begin
            miscompares++;
            $display("FAIL rst_mid_rerun: got n=%0d ops=%0d d0=%0h d3=%0h required 10 9 10 1",
                     done_n, log_cnt, log_data[0], log_data[3]);
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== {32'h31, 32'h32, 32'hABC1}) begin
            miscompares++;
            $display("FAIL rst_mid_res: got %0h %0h %0h required 31 32 abc1", res_addr, res_data, res_status);
        end
    endtask

`ifdef SRAM_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int polls;
        int other_rd;
        set_cfg(32'h10, 32'h20, 32'h3, 32'h1);
        done_poll = 0;
        reg5 = 32'hBAD1;
        reg6 = 32'hBAD2;
        run_seq(48, 0);
        polls    = 0;
        other_rd = 0;
        for (int i = 0; i < log_cnt; i++) begin
            if (!log_wr[i] && log_addr[i] == 3'd7) polls++;
            if (!log_wr[i] && log_addr[i] != 3'd7) other_rd++;
        end
        vectors++;
        if (polls !== 8 || other_rd !== 0) begin
            miscompares++;
            $display("FAIL tmo_polls: got polls=%0d other=%0d required 8 0", polls, other_rd);
        end
        vectors++;
        if (done_n !== 43 || tmo_n !== 43 || tmo_cnt !== 1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL tmo_pulse: got done@%0d tmo@%0d cnt=%0d/%0d required 43 43 1/1",
                     done_n, tmo_n, tmo_cnt, done_cnt);
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== {32'h31, 32'h32, 32'hABF0}) begin
            miscompares++;
            $display("FAIL tmo_res: got %0h %0h %0h required 31 32 abf0", res_addr, res_data, res_status);
        end
    endtask
`else
    task automatic test_long_poll();
        set_cfg(32'h10, 32'h20, 32'h3, 32'h1);
        done_poll = 10;
        reg5 = 32'hC5;
        reg6 = 32'hC6;
        run_seq(58, 0);
        vectors++;
        if (done_n !== 55 || tmo_cnt !== 0 || log_cnt !== 18) begin
            miscompares++;
            $display("FAIL long_poll: got n=%0d tmo=%0d ops=%0d required 55 0 18", done_n, tmo_cnt, log_cnt);
        end
        vectors++;
        if ({res_addr, res_data, res_status} !== {32'hC5, 32'hC6, 32'hABD1}) begin
            miscompares++;
            $display("FAIL long_poll_res: got %0h %0h %0h required c5 c6 abd1", res_addr, res_data, res_status);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        m_waitrequest = 1'b0;
        poll_clr      = 1'b1;
        done_poll     = 0;
        reg5          = 32'd0;
        reg6          = 32'd0;
        stall_op_left = 0;
        stall_rd_left = 0;
        set_cfg(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_polling();
        test_waitrequest();
        test_busy_start();
        test_reset_mid();
`ifdef SRAM_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_long_poll();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avalon_sram_master.md
# avalon_sram_master

Avalon-MM master sequencer that drives the SRAM-test register slave from the other end of the bus. On a `start` pulse it writes the four configuration registers, pulses the send register, polls the status register until the done bit is set, and reads back the result address and data. It sits between a local controller (or CPU-less test harness) and the SRAM register slave. It converts one start command into a complete bus transaction sequence and returns results.

## Interface
Parameters:
- `DONE_BIT`, 0: bit of status register (addr 7) that signals operation complete
- `POLL_GAP`, 4: idle bus cycles between consecutive status polls (0 allowed)
- `POLL_MAX`, 1024: maximum status reads before timeout (only with timeout feature)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: launch sequence; sampled only in IDLE
- `cfg_sta_addr` / `cfg_area` / `cfg_op` / `cfg_enable` in 32 each: values for slave regs 0/1/2/4, captured on accepted `start`
- `m_chipselect` out 1; `m_address` out 3; `m_write` out 1; `m_read` out 1; `m_writedata` out 32
- `m_readdata` in 32: zero-latency read data, valid in accepting cycle
- `m_waitrequest` in 1: slave stall
- `busy` out 1: high from cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse at sequence end
- `timeout` out 1: one-cycle pulse, coincident with `done`, when poll limit hit
- `res_addr` / `res_data` / `res_status` out 32: regs 5 / 6 / last polled reg 7

## Operation
- States: IDLE, WR_STA, WR_AREA, WR_OP, WR_EN, WR_SEND, WR_CLR, POLL, GAP, RD_ADDR, RD_DATA, FIN.
- Bus ops: WR_STA addr 0, WR_AREA addr 1, WR_OP addr 2, WR_EN addr 4 (captured cfg values); WR_SEND addr 3 data 1; WR_CLR addr 3 data 0; POLL read addr 7; RD_ADDR read addr 5; RD_DATA read addr 6.
- A transfer completes in a cycle with `m_chipselect & (m_read|m_write) & !m_waitrequest`; state advances on that edge only. Address, data, and strobes stay stable while `m_waitrequest`=1.
- `m_read` and `m_write` are never both high. `m_chipselect` is high only with a strobe.
- POLL completion: `m_readdata` goes to `res_status`. If bit `DONE_BIT`=1, go to RD_ADDR. Otherwise go to GAP (or POLL directly if `POLL_GAP`=0).
- GAP counts `POLL_GAP` cycles with all strobes low, then returns to POLL.
- RD_ADDR / RD_DATA completion loads `res_addr` / `res_data`.
- FIN: `done`=1 for one cycle, `busy`=0, return to IDLE. `res_*` hold until the next sequence overwrites them.
- `start` while busy: ignored. `start` held high in IDLE after FIN: relaunches.
- Reset (including mid-transfer): next edge forces IDLE. All outputs go to 0, including `res_*`, strobes, counters, and captured cfg. Any transfer in flight is abandoned.

## Timing
- `start` is sampled at edge k. `busy` and the first `m_write` (addr 0) are high from k+1.
- With `m_waitrequest`=0 there is one cycle per op: writes occupy cycles k+1..k+6 and the first poll is at k+7.
- If the first poll shows done: RD_ADDR at k+8, RD_DATA at k+9, `done` at k+10. Minimum latency is 10 cycles.
- Each additional poll adds `POLL_GAP`+1 cycles.
- Each waitrequest cycle extends the current op by exactly one cycle.
- `res_*` update on the edge ending the accepting cycle. They are valid no later than `done`.

## Configuration
- `SRAM_MASTER_TIMEOUT_EN` defined: a poll counter increments per completed POLL. After the `POLL_MAX`-th poll without done, the FSM skips RD_ADDR/RD_DATA and goes to FIN with `timeout`=1. `res_addr`/`res_data` keep their previous values.
- Not defined: polling is unbounded, no counter is synthesized, and `timeout` is tied 0.

## Test plan
- Basic: `start`, cfg = 0x10/0x20/0x3/0x1, waitrequest=0, slave status bit0 set on first poll, regs 5/6 = 0x3FF/0xA5 -> writes 0:0x10, 1:0x20, 2:0x3, 4:0x1, 3:1, 3:0 in order; `done` at k+10; `res_addr`=0x3FF, `res_data`=0xA5.
- Polling: status done on 3rd poll, `POLL_GAP`=4 -> exactly 3 reads of addr 7, 4 idle cycles between them; `done` at k+20.
- Waitrequest: hold `m_waitrequest`=1 for 3 cycles on WR_OP and 2 on RD_DATA -> signals stable during stall, same op order, `done` 5 cycles later than baseline.
- Timeout (macro on, `POLL_MAX`=8): status never done -> 8 polls, no reads of addr 5/6, `done`=`timeout`=1 same cycle, `res_status` = last polled value.
- Reset mid-op: assert `reset` during POLL -> next cycle all outputs 0, IDLE; a new `start` runs a full correct sequence.
- `start` pulsed during busy -> ignored; exactly one `done`.
